// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared definitions for the data-memory arbiter:
//   - arb_state_e : owner of the most recently granted RAM cycle
//   - DATAWIDTH_DEF / ADDR_W_DEF : default data and RAM word-address widths
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

   localparam int DATAWIDTH_DEF = 32;
   localparam int ADDR_W_DEF    = 14;

   // IDLE: nothing granted last cycle; OWN0/OWN1: port 0/1 owned last cycle
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_e;

endpackage

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Two-requester arbiter in front of a single-port data RAM with asynchronous
// read data. Port 0 is the CPU, port 1 the loader/DMA. One access per cycle;
// the grant is combinational so a lone requester is served in the same cycle.
// Read data is captured at the end of the grant cycle and presented with a
// one-cycle rvalid pulse.
//
// Optional feature: define DMEM_ARB_BURST_EN to let port 1 keep the RAM for up
// to MAX_BURST consecutive beats while port 0 is also requesting. Without it
// the two ports strictly alternate under contention.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   pX_req/wen/addr/din      request, write enable, address, write data (X=0,1)
//   pX_gnt                   access performed this cycle
//   pX_rvalid/pX_rdata       one-cycle read-valid pulse, held read data
//   ram_ena/wen/addr/din     RAM control toward the external data RAM
//   ram_dout                 asynchronous RAM read data
// -----------------------------------------------------------------------------
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int DATAWIDTH = DATAWIDTH_DEF,
   parameter int ADDR_W    = ADDR_W_DEF,
   parameter int MAX_BURST = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 p0_req,
   input  logic                 p0_wen,
   input  logic [DATAWIDTH-1:0] p0_addr,
   input  logic [DATAWIDTH-1:0] p0_din,
   output logic                 p0_gnt,
   output logic                 p0_rvalid,
   output logic [DATAWIDTH-1:0] p0_rdata,
   input  logic                 p1_req,
   input  logic                 p1_wen,
   input  logic [DATAWIDTH-1:0] p1_addr,
   input  logic [DATAWIDTH-1:0] p1_din,
   output logic                 p1_gnt,
   output logic                 p1_rvalid,
   output logic [DATAWIDTH-1:0] p1_rdata,
   output logic                 ram_ena,
   output logic                 ram_wen,
   output logic [ADDR_W-1:0]    ram_addr,
   output logic [DATAWIDTH-1:0] ram_din,
   input  logic [DATAWIDTH-1:0] ram_dout
);

   localparam logic [3:0] MAX_BURST_C = 4'(MAX_BURST);

   arb_state_e state_r;
   arb_state_e state_nxt_s;
   logic       gnt0_s;
   logic       gnt1_s;

   // Upper address bits are intentionally ignored by the RAM
   logic unused_s;
   assign unused_s = ^{p0_addr[DATAWIDTH-1:ADDR_W], p1_addr[DATAWIDTH-1:ADDR_W], MAX_BURST_C};

`ifdef DMEM_ARB_BURST_EN
   // Consecutive port-1 beats taken while port 0 was waiting
   logic [3:0] burst_cnt_r;

   // Burst counter: only contended port-1 grants count toward the limit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         burst_cnt_r <= 4'd0;
      end else if (gnt1_s && p0_req) begin
         burst_cnt_r <= (burst_cnt_r == 4'hF) ? 4'hF : burst_cnt_r + 4'd1;
      end else begin
         burst_cnt_r <= 4'd0;
      end
   end
`endif

   // Arbitration: lone requester wins; contention resolved from last owner
   always_comb begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
      if (rst) begin
         gnt0_s = 1'b0;
         gnt1_s = 1'b0;
      end else if (p0_req && p1_req) begin
         case (state_r)
            IDLE: gnt0_s = 1'b1;
            OWN0: gnt1_s = 1'b1;
`ifdef DMEM_ARB_BURST_EN
            OWN1: begin
               if (burst_cnt_r < MAX_BURST_C) begin
                  gnt1_s = 1'b1;
               end else begin
                  gnt0_s = 1'b1;
               end
            end
`else
            OWN1: gnt0_s = 1'b1;
`endif
            default: gnt0_s = 1'b1;
         endcase
      end else if (p0_req) begin
         gnt0_s = 1'b1;
      end else if (p1_req) begin
         gnt1_s = 1'b1;
      end else begin
         gnt0_s = 1'b0;
         gnt1_s = 1'b0;
      end
   end

   // Next state records who owned this cycle
   always_comb begin
      state_nxt_s = IDLE;
      if (gnt0_s) begin
         state_nxt_s = OWN0;
      end else if (gnt1_s) begin
         state_nxt_s = OWN1;
      end else begin
         state_nxt_s = IDLE;
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // RAM-side mux; all fields forced to zero when no one is granted
   always_comb begin
      ram_ena  = 1'b0;
      ram_wen  = 1'b0;
      ram_addr = {ADDR_W{1'b0}};
      ram_din  = {DATAWIDTH{1'b0}};
      if (gnt0_s) begin
         ram_ena  = 1'b1;
         ram_wen  = p0_wen;
         ram_addr = p0_addr[ADDR_W-1:0];
         ram_din  = p0_din;
      end else if (gnt1_s) begin
         ram_ena  = 1'b1;
         ram_wen  = p1_wen;
         ram_addr = p1_addr[ADDR_W-1:0];
         ram_din  = p1_din;
      end else begin
         ram_ena  = 1'b0;
      end
   end

   assign p0_gnt = gnt0_s;
   assign p1_gnt = gnt1_s;

   // Read return: capture async RAM data at the end of a read grant
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p0_rvalid <= 1'b0;
         p1_rvalid <= 1'b0;
         p0_rdata  <= {DATAWIDTH{1'b0}};
         p1_rdata  <= {DATAWIDTH{1'b0}};
      end else begin
         p0_rvalid <= gnt0_s & ~p0_wen;
         p1_rvalid <= gnt1_s & ~p1_wen;
         if (gnt0_s && !p0_wen) begin
            p0_rdata <= ram_dout;
         end
         if (gnt1_s && !p1_wen) begin
            p1_rdata <= ram_dout;
         end
      end
   end

endmodule
